id_hazard_ctrl: RTL and testbench
=================================

ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 2, width of each per-register pending-write counter (max in-flight writes per rd = 2^CNT_W-1).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port issue_valid  input  1  decode holds a valid instruction requesting issue.
REQ-005 SHALL have ports issue_rs1/issue_rs2/issue_rd  input  5 each  decoded register numbers.
REQ-006 SHALL have ports issue_has_rs1/issue_has_rs2/issue_has_rd  input  1 each  operand-use flags from decode.
REQ-007 SHALL have ports wb_valid  input  1, wb_rd  input  5  writeback retiring one write to wb_rd.
REQ-008 SHALL have port flush  input  1  squash all in-flight writes and the current issue.
REQ-009 SHALL have port stall  output  1  hold decode this cycle.
REQ-010 SHALL have port issue_fire  output  1  instruction accepted this cycle.
REQ-011 SHALL have port pend_mask  output  32  bit r = 1 when cnt[r] != 0 (bit 0 always 0).
REQ-012 SHALL have port stall_cnt  output  16  saturating count of stalled cycles.
REQ-013 SHALL have port err_underflow  output  1  sticky: writeback seen for register with cnt 0.

Function
REQ-014 SHALL hold 31 registered counters cnt[1..31], CNT_W bits each; register x0 never tracked, never hazards.
REQ-015 SHALL define eff[r] = cnt[r] (see Configuration for bypass adjustment).
REQ-016 SHALL assert raw hazard when (issue_has_rs1 && rs1!=0 && eff[rs1]!=0) or same for rs2.
REQ-017 SHALL assert capacity hazard when issue_has_rd && rd!=0 && eff[rd] == 2^CNT_W-1.
REQ-018 SHALL drive stall = issue_valid && !flush && (raw || capacity hazard), combinationally, same cycle.
REQ-019 SHALL drive issue_fire = issue_valid && !flush && !stall; stall and issue_fire never both 1.
REQ-020 SHALL at each clk edge, per r: +1 if issue_fire && issue_has_rd && rd==r; -1 if wb_valid && wb_rd==r && cnt[r]!=0; both -> unchanged.
REQ-021 SHALL ignore wb_valid with wb_rd==0.
REQ-022 SHALL, on wb_valid with wb_rd!=0 and cnt[wb_rd]==0, leave counter 0 and set err_underflow at next edge; it stays 1 until reset.
REQ-023 SHALL, on flush, clear every cnt to 0 at next edge, overriding same-cycle issue and writeback updates; err_underflow not checked in a flush cycle.
REQ-024 SHALL increment stall_cnt at each edge where stall==1, saturating at 0xFFFF.
REQ-025 SHALL derive pend_mask from registered counters only (no same-cycle input dependence).
REQ-026 SHALL have zero-cycle latency from inputs to stall/issue_fire; counter updates visible one cycle later.

Reset
REQ-027 SHALL, while rst=1, asynchronously force all cnt=0, stall_cnt=0, err_underflow=0.
REQ-028 SHALL force stall=0 and issue_fire=0 while rst=1.
REQ-029 SHALL resume normal operation at the first clk edge after rst deasserts; rst mid-operation discards all pending state.

Configuration
REQ-030 SHALL, with macro ID_HAZARD_WB_BYPASS_EN defined, use eff[r] = cnt[r] - 1 when wb_valid && wb_rd==r && cnt[r]!=0, else cnt[r] (same-cycle writeback releases the hazard).
REQ-031 SHALL, without ID_HAZARD_WB_BYPASS_EN, use eff[r] = cnt[r]; a reader stalls through the writeback cycle and fires the cycle after.

Verification
REQ-032 SHALL cover: issue rd=5 fire; next cycle issue rs1=5 -> stall=1, pend_mask[5]=1; wb_rd=5 -> bypass build fires same cycle, non-bypass fires next cycle.
REQ-033 SHALL cover: CNT_W=2, three fired writes to rd=7 with no wb -> fourth issue rd=7 stalls; one wb_rd=7 -> it fires (bypass same cycle, else next).
REQ-034 SHALL cover: issue rd=0 and rs1=0 repeatedly -> never stalls, pend_mask stays 0.
REQ-035 SHALL cover: wb_valid wb_rd=9 with cnt[9]=0 -> err_underflow=1 next cycle, cnt[9] stays 0, persists until rst.
REQ-036 SHALL cover: cnt[3]=2, cnt[4]=1, flush with issue_valid rd=3 and wb_rd=4 -> issue_fire=0, stall=0, all pend_mask 0 next cycle.
REQ-037 SHALL cover: 70000 consecutive stalled cycles -> stall_cnt=0xFFFF; async rst mid-clock -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : id_hazard_ctrl
//  Purpose  : Decode-stage hazard controller. Tracks in-flight writes to each
//             architectural register (x1..x31) with small counters, stalls
//             decode on read-after-write or counter-capacity hazards, and
//             keeps a saturating stalled-cycle counter plus a sticky
//             writeback-underflow flag.
//  Ports    : clk, rst (async, active-high)
//             issue_valid, issue_rs1/rs2/rd, issue_has_rs1/rs2/rd  - decode
//             wb_valid, wb_rd                                     - writeback
//             flush                                               - squash
//             stall, issue_fire                 - same-cycle issue decision
//             pend_mask[31:0]                   - registered pending writes
//             stall_cnt[15:0], err_underflow    - status
//  Options  : `define ID_HAZARD_WB_BYPASS_EN lets a same-cycle writeback
//             release the hazard it retires.
//  Revision : 1.0 - initial release
// ============================================================================
module id_hazard_ctrl #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic [4:0]  issue_rd,
    input  logic        issue_has_rs1,
    input  logic        issue_has_rs2,
    input  logic        issue_has_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        flush,
    output logic        stall,
    output logic        issue_fire,
    output logic [31:0] pend_mask,
    output logic [15:0] stall_cnt,
    output logic        err_underflow
);

    localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [15:0]      c_STALL_MAX = 16'hFFFF;

    logic [31:0][CNT_W-1:0] cnt_q;
    logic [31:0][CNT_W-1:0] cnt_d;
    logic [31:0][CNT_W-1:0] w_eff;
    logic                   w_raw_hazard;
    logic                   w_cap_hazard;
    logic                   w_wb_retire;
    logic                   err_underflow_q;
    logic                   err_underflow_d;
    logic [15:0]            stall_cnt_q;
    logic [15:0]            stall_cnt_d;

    // A writeback only retires something when its counter is non-zero.
    assign w_wb_retire = wb_valid && (wb_rd != 5'd0) && (cnt_q[wb_rd] != '0);

    // Effective in-flight count seen by the hazard checks.
    always_comb begin
        w_eff = cnt_q;
`ifdef ID_HAZARD_WB_BYPASS_EN
        if (w_wb_retire) begin
            w_eff[wb_rd] = cnt_q[wb_rd] - c_CNT_ONE;
        end
`endif
    end

    assign w_raw_hazard = (issue_has_rs1 && (issue_rs1 != 5'd0) && (w_eff[issue_rs1] != '0)) ||
                          (issue_has_rs2 && (issue_rs2 != 5'd0) && (w_eff[issue_rs2] != '0));
    assign w_cap_hazard = issue_has_rd && (issue_rd != 5'd0) && (w_eff[issue_rd] == c_CNT_MAX);

    // Gating with rst keeps both decisions low while reset is held.
    assign stall      = !rst && issue_valid && !flush &&  (w_raw_hazard || w_cap_hazard);
    assign issue_fire = !rst && issue_valid && !flush && !(w_raw_hazard || w_cap_hazard);

    // Increment then decrement the same slot so a matching issue/writeback
    // pair cancels. The capacity check guarantees the increment never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            if (issue_fire && issue_has_rd && (issue_rd != 5'd0)) begin
                cnt_d[issue_rd] = cnt_d[issue_rd] + c_CNT_ONE;
            end
            if (w_wb_retire) begin
                cnt_d[wb_rd] = cnt_d[wb_rd] - c_CNT_ONE;
            end
        end
        cnt_d[0] = '0;
    end

    always_comb begin
        err_underflow_d = err_underflow_q;
        if (!flush && wb_valid && (wb_rd != 5'd0) && (cnt_q[wb_rd] == '0)) begin
            err_underflow_d = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != c_STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            err_underflow_q <= 1'b0;
            stall_cnt_q     <= 16'd0;
        end else begin
            cnt_q           <= cnt_d;
            err_underflow_q <= err_underflow_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    assign pend_mask[0] = 1'b0;
    for (genvar r = 1; r < 32; r++) begin : g_pend
        assign pend_mask[r] = |cnt_q[r];
    end

    assign stall_cnt     = stall_cnt_q;
    assign err_underflow = err_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_id_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_hazard_ctrl
//  Purpose  : Self-checking bench for id_hazard_ctrl against a behavioural
//             model of per-register in-flight write counts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_id_hazard_ctrl;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef ID_HAZARD_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk, rst;
    logic        issue_valid, issue_has_rs1, issue_has_rs2, issue_has_rd;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
    logic        wb_valid, flush;
    logic        stall, issue_fire, err_underflow;
    logic [31:0] pend_mask;
    logic [15:0] stall_cnt;

    id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
        .issue_has_rs1(issue_has_rs1), .issue_has_rs2(issue_has_rs2), .issue_has_rd(issue_has_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .pend_mask(pend_mask),
        .stall_cnt(stall_cnt), .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: number of outstanding writes per register.
    int mcnt[32];
    bit merr;
    int msc;
    bit m_stall, m_fire;
    bit obs_stall, obs_fire;

    task automatic model_reset();
        foreach (mcnt[r]) mcnt[r] = 0;
        merr = 1'b0;
        msc  = 0;
    endtask

    function automatic int eff(input int r);
        if (r == 0) return 0;
        if (BYPASS && wb_valid && (int'(wb_rd) == r) && mcnt[r] > 0) return mcnt[r] - 1;
        return mcnt[r];
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        for (int r = 1; r < 32; r++) if (mcnt[r] != 0) m[r] = 1'b1;
        return m;
    endfunction

    task automatic model_eval();
        bit haz;
        haz = (issue_has_rs1 && issue_rs1 != 0 && eff(int'(issue_rs1)) > 0) ||
              (issue_has_rs2 && issue_rs2 != 0 && eff(int'(issue_rs2)) > 0) ||
              (issue_has_rd  && issue_rd  != 0 && eff(int'(issue_rd)) == MAXC);
        m_stall = issue_valid && !flush && haz;
        m_fire  = issue_valid && !flush && !haz;
    endtask

    task automatic model_tick();
        int old[32];
        if (flush) begin
            foreach (mcnt[r]) mcnt[r] = 0;
        end else begin
            if (wb_valid && wb_rd != 0 && mcnt[wb_rd] == 0) merr = 1'b1;
            old = mcnt;
            for (int r = 1; r < 32; r++) begin
                int n = old[r];
                if (m_fire && issue_has_rd && int'(issue_rd) == r) n++;
                if (wb_valid && int'(wb_rd) == r && old[r] > 0) n--;
                mcnt[r] = n;
            end
        end
        if (m_stall && msc < 65535) msc++;
    endtask

    // Sample decisions mid-cycle, then advance DUT and model one edge.
    task automatic tick();
        #3;
        obs_stall = stall;
        obs_fire  = issue_fire;
        model_eval();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic set_idle();
        issue_valid = 0; issue_has_rs1 = 0; issue_has_rs2 = 0; issue_has_rd = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic set_issue(input bit v, input int rs1, input int rs2, input int rd);
        issue_valid = v;
        issue_has_rs1 = (rs1 >= 0); issue_rs1 = (rs1 >= 0) ? 5'(rs1) : 5'd0;
        issue_has_rs2 = (rs2 >= 0); issue_rs2 = (rs2 >= 0) ? 5'(rs2) : 5'd0;
        issue_has_rd  = (rd  >= 0); issue_rd  = (rd  >= 0) ? 5'(rd)  : 5'd0;
    endtask

    task automatic do_flush();
        set_idle();
        flush = 1;
        tick();
        flush = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1;
        set_issue(1, -1, -1, 3);
        #2;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (issue_fire !== 1'b0) begin errors++; $display("FAIL reset_fire got %b exp 0", issue_fire); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", pend_mask); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_stall_cnt got %h exp 0", stall_cnt); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_underflow); end
        @(posedge clk); #1;
        rst = 0;
        set_idle();
        model_reset();
    endtask

    // Write to x5, then a reader of x5 waits for its writeback.
    task automatic test_raw_wb();
        for (int c = 0; c < 4; c++) begin
            set_idle();
            case (c)
                0: set_issue(1, -1, -1, 5);
                default: set_issue(1, 5, -1, -1);
            endcase
            if (c == 2) begin wb_valid = 1; wb_rd = 5; end
            if (c == 1) begin
                checks++; if (pend_mask[5] !== 1'b1) begin errors++; $display("FAIL raw_pend5 got %b exp 1", pend_mask[5]); end
            end
            tick();
            checks++; if (obs_stall !== m_stall) begin errors++; $display("FAIL raw_stall c%0d got %b exp %b", c, obs_stall, m_stall); end
            checks++; if (obs_fire !== m_fire) begin errors++; $display("FAIL raw_fire c%0d got %b exp %b", c, obs_fire, m_fire); end
            checks++; if (pend_mask !== model_mask()) begin errors++; $display("FAIL raw_mask c%0d got %h exp %h", c, pend_mask, model_mask()); end
        end
        do_flush();
    endtask

    // Fill x7 to capacity, then one writeback makes room.
    task automatic test_capacity();
        for (int c = 0; c < 6; c++) begin
            set_idle();
            set_issue(1, -1, -1, 7);
            if (c == 4) begin wb_valid = 1; wb_rd = 7; end
            tick();
            checks++; if (obs_stall !== m_stall) begin errors++; $display("FAIL cap_stall c%0d got %b exp %b", c, obs_stall, m_stall); end
            checks++; if (obs_fire !== m_fire) begin errors++; $display("FAIL cap_fire c%0d got %b exp %b", c, obs_fire, m_fire); end
            if (c == 3) begin
                checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL cap_full_stall got %b exp 1", obs_stall); end
            end
        end
        do_flush();
    endtask

    task automatic test_x0();
        for (int c = 0; c < 8; c++) begin
            set_idle();
            set_issue(1, 0, 0, 0);
            tick();
            checks++; if (obs_stall !== 1'b0 || obs_fire !== 1'b1) begin errors++; $display("FAIL x0_issue c%0d got stall %b fire %b exp 0 1", c, obs_stall, obs_fire); end
            checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL x0_mask c%0d got %h exp 0", c, pend_mask); end
        end
    endtask

    task automatic test_underflow();
        set_idle();
        wb_valid = 1; wb_rd = 9;
        tick();
        set_idle();
        checks++; if (err_underflow !== 1'b1) begin errors++; $display("FAIL uf_err got %b exp 1", err_underflow); end
        checks++; if (pend_mask[9] !== 1'b0) begin errors++; $display("FAIL uf_cnt9 got %b exp 0", pend_mask[9]); end
        for (int c = 0; c < 3; c++) tick();
        do_flush();
        checks++; if (err_underflow !== merr) begin errors++; $display("FAIL uf_sticky got %b exp %b", err_underflow, merr); end
    endtask

    task automatic test_flush();
        set_idle();
        set_issue(1, -1, -1, 3); tick();
        set_issue(1, -1, -1, 3); tick();
        set_issue(1, -1, -1, 4); tick();
        checks++; if (pend_mask !== model_mask()) begin errors++; $display("FAIL fl_pre_mask got %h exp %h", pend_mask, model_mask()); end
        set_issue(1, -1, -1, 3);
        wb_valid = 1; wb_rd = 4; flush = 1;
        tick();
        set_idle();
        checks++; if (obs_fire !== 1'b0 || obs_stall !== 1'b0) begin errors++; $display("FAIL fl_issue got stall %b fire %b exp 0 0", obs_stall, obs_fire); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL fl_mask got %h exp 0", pend_mask); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            issue_valid   = ($urandom_range(3) != 0);
            issue_has_rs1 = $urandom_range(1); issue_rs1 = 5'($urandom_range(5));
            issue_has_rs2 = $urandom_range(1); issue_rs2 = 5'($urandom_range(5));
            issue_has_rd  = $urandom_range(1); issue_rd  = 5'($urandom_range(5));
            wb_valid      = ($urandom_range(2) == 0); wb_rd = 5'($urandom_range(5));
            flush         = ($urandom_range(24) == 0);
            tick();
            checks++; if (obs_stall !== m_stall || obs_fire !== m_fire) begin errors++; $display("FAIL rnd_issue c%0d got stall %b fire %b exp %b %b", c, obs_stall, obs_fire, m_stall, m_fire); end
            checks++; if (pend_mask !== model_mask()) begin errors++; $display("FAIL rnd_mask c%0d got %h exp %h", c, pend_mask, model_mask()); end
            checks++; if (err_underflow !== merr) begin errors++; $display("FAIL rnd_err c%0d got %b exp %b", c, err_underflow, merr); end
            checks++; if (int'(stall_cnt) !== msc) begin errors++; $display("FAIL rnd_stall_cnt c%0d got %0d exp %0d", c, stall_cnt, msc); end
        end
        set_idle();
    endtask

    task automatic test_stall_saturate_and_async_reset();
        do_flush();
        set_issue(1, -1, -1, 1); tick();
        set_issue(1, 1, -1, -1);
        for (int c = 0; c < 70000; c++) tick();
        checks++; if (stall_cnt !== 16'hFFFF || msc != 65535) begin errors++; $display("FAIL sat_stall_cnt got %h exp ffff", stall_cnt); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sat_still_stall got %b exp 1", stall); end
        // Reader of x1 still presented; reset lands between edges.
        #2;
        rst = 1;
        #1;
        checks++; if (stall !== 1'b0 || issue_fire !== 1'b0) begin errors++; $display("FAIL ar_issue got stall %b fire %b exp 0 0", stall, issue_fire); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL ar_mask got %h exp 0", pend_mask); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL ar_stall_cnt got %h exp 0", stall_cnt); end
        checks++; if (err_underflow !== 1'b0) begin errors++; $display("FAIL ar_err got %b exp 0", err_underflow); end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
        tick();
        checks++; if (obs_fire !== 1'b1) begin errors++; $display("FAIL ar_resume got fire %b exp 1", obs_fire); end
        set_idle();
    endtask

    initial begin
        rst = 1;
        set_idle();
        model_reset();
        test_reset();
        test_raw_wb();
        test_capacity();
        test_x0();
        test_underflow();
        test_flush();
        test_random();
        test_stall_saturate_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
